// File: rtl/riscv_dbg_pkg.sv
// riscv_dbg_pkg: shared debug-block constants and the register-dump FSM state type
package riscv_dbg_pkg;
  localparam int XLEN_DEFAULT = 64;
  localparam int NUM_REGS_DEFAULT = 32;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dump_state_e;
endpackage

// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: streams an external register file out as handshaked beats with a running checksum
module regfile_dump_unit
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter bit SKIP_X0 = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [4:0]      dump_index,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_last,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] checksum
);
  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [4:0] FIRST_IDX = SKIP_X0 ? 5'd1 : 5'd0;
  dump_state_e state_q, state_d;
  logic [4:0] idx_q, idx_d, index_q, index_d;
  logic [XLEN-1:0] data_q, data_d, sum_q, sum_d;
  logic last_q, last_d;
  // walk the index, capture one register per READ, accumulate on each accepted beat; abort overrides the state only
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    index_d = index_q;
    data_d = data_q;
    last_d = last_q;
    sum_d = sum_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        idx_d = FIRST_IDX;
        sum_d = '0;
      end
      READ: begin
        state_d = SEND;
        index_d = idx_q;
        data_d = rf_rdata;
        last_d = idx_q == LAST_IDX;
      end
      SEND: if (dump_ready) begin
        sum_d = sum_q + data_q;
        state_d = last_q ? DONE : READ;
        idx_d = last_q ? idx_q : idx_q + 5'd1;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      index_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      index_q <= index_d;
      data_q <= data_d;
      last_q <= last_d;
      sum_q <= sum_d;
    end
  end
  assign rf_raddr = state_q == IDLE ? 5'd0 : idx_q;
  assign dump_valid = state_q == SEND;
  assign dump_index = index_q;
  assign dump_data = data_q;
  assign dump_last = last_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign checksum = sum_q;
endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: scoreboard bench for the register dump unit, with and without x0 skipped
module tb_regfile_dump_unit;
  typedef struct {
    int idx;
    logic [63:0] data;
    bit last;
  } beat_t;
  logic clk = 0, reset = 0, start = 0, abort = 0, ready = 0;
  logic sel = 0;
  logic [63:0] rf [2][32];
  logic [4:0] raddr [2], didx [2];
  logic [63:0] rdata [2], ddata [2], csum [2];
  logic dv [2], dl [2], bsy [2], dn [2];
  logic v_m, l_m, bsy_m, dn_m;
  logic [4:0] i_m, ra_m;
  logic [63:0] d_m, cs_m;
  beat_t q[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign rdata[g] = rf[g][raddr[g]];
    regfile_dump_unit #(.XLEN(64), .NUM_REGS(32), .SKIP_X0(g == 1)) dut (
      .clk(clk), .reset(reset), .start(start && sel == g), .abort(abort && sel == g),
      .rf_raddr(raddr[g]), .rf_rdata(rdata[g]), .dump_valid(dv[g]), .dump_ready(ready),
      .dump_index(didx[g]), .dump_data(ddata[g]), .dump_last(dl[g]), .busy(bsy[g]),
      .done(dn[g]), .checksum(csum[g])
    );
  end
  assign v_m = dv[sel];
  assign l_m = dl[sel];
  assign bsy_m = bsy[sel];
  assign dn_m = dn[sel];
  assign i_m = didx[sel];
  assign ra_m = raddr[sel];
  assign d_m = ddata[sel];
  assign cs_m = csum[sel];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: every accepted beat is popped and compared; stalled beats must hold still
  logic stall = 0, p_last = 0;
  logic [4:0] p_idx = 0;
  logic [63:0] p_data = 0;
  always @(negedge clk) begin
    beat_t e;
    if (v_m) begin
      if (stall) begin
        chk("hold_index", 64'(i_m), 64'(p_idx));
        chk("hold_data", d_m, p_data);
        chk("hold_last", 64'(l_m), 64'(p_last));
      end
      if (ready) begin
        if (q.size() == 0) chk("unexpected_beat", 64'(i_m), 64'hffff);
        else begin
          e = q.pop_front();
          chk("beat_index", 64'(i_m), 64'(e.idx));
          chk("beat_data", d_m, e.data);
          chk("beat_last", 64'(l_m), 64'(e.last));
        end
      end
      stall <= !ready;
      p_idx <= i_m;
      p_data <= d_m;
      p_last <= l_m;
    end else stall <= 1'b0;
  end
  task automatic check_reset();
    chk("rst_valid", 64'(v_m), 0);
    chk("rst_last", 64'(l_m), 0);
    chk("rst_busy", 64'(bsy_m), 0);
    chk("rst_done", 64'(dn_m), 0);
    chk("rst_index", 64'(i_m), 0);
    chk("rst_data", d_m, 0);
    chk("rst_checksum", cs_m, 0);
    chk("rst_raddr", 64'(ra_m), 0);
  endtask
  // mode 0: ready high, 1: ready one cycle in three, 2: random ready and stray starts; abort_n>0 aborts on that handshake
  task automatic run_dump(input logic s, input int mode, input int abort_n);
    int cyc = 0, hs = 0, first_v = -1, last_hs = -1, first;
    bit seen_done = 0, aborted = 0;
    logic [63:0] sum = '0;
    sel = s;
    first = s ? 1 : 0;
    for (int i = first; i < 32; i++)
      if (abort_n == 0 || i - first < abort_n) begin
        q.push_back('{i, rf[s][i], i == 31});
        sum += rf[s][i];
      end
    @(posedge clk);
    #1 reset = 1;
    start = 1;
    ready = mode == 0;
    while (1) begin
      @(posedge clk);
      #1 start = 0;
      abort = 0;
      cyc++;
      if (cyc > 400) begin
        chk("timeout", 64'(cyc), 0);
        break;
      end
      if (aborted || seen_done) begin
        chk("end_busy", 64'(bsy_m), 0);
        chk("end_valid", 64'(v_m), 0);
        chk("end_done", 64'(dn_m), 0);
        chk("end_checksum", cs_m, sum);
        break;
      end
      if (cyc == 1) chk("read_busy", 64'(bsy_m), 1);
      if (dn_m) begin
        chk("done_unexpected", 64'(abort_n), 0);
        chk("done_timing", 64'(cyc), 64'(last_hs + 1));
        chk("done_busy", 64'(bsy_m), 1);
        seen_done = 1;
      end
      if (first_v < 0 && v_m) begin
        first_v = cyc;
        chk("latency", 64'(cyc), 2);
      end
      ready = mode == 0 ? 1'b1 : mode == 1 ? cyc % 3 == 0 : 1'($urandom_range(0, 1));
      start = mode == 2 && $urandom_range(0, 7) == 0;
      if (v_m && ready) begin
        hs++;
        last_hs = cyc;
        if (abort_n != 0 && hs == abort_n) begin
          abort = 1;
          aborted = 1;
        end
      end
    end
    start = 0;
    abort = 0;
    ready = 0;
    chk("queue_drained", 64'(q.size()), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 chk("checksum_hold", cs_m, sum);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[0][i] = 64'(i * 3);
      rf[1][i] = 64'd1;
    end
    repeat (2) @(posedge clk);
    #1 sel = 0;
    #1 check_reset();
    sel = 1;
    #1 check_reset();
    run_dump(0, 0, 0);
    run_dump(0, 1, 0);
    run_dump(1, 2, 0);
    run_dump(0, 2, 5);
    for (int i = 0; i < 32; i++) rf[0][i] = '0;
    rf[0][31] = '1;
    run_dump(0, 0, 0);
    rf[0][1] = 64'd1;
    run_dump(0, 1, 0);
    sel = 0;
    @(posedge clk);
    #1 start = 1;
    ready = 0;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(posedge clk);
    #1 chk("stall_valid", 64'(v_m), 1);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("start_ignored_valid", 64'(v_m), 1);
    chk("start_ignored_index", 64'(i_m), 0);
    reset = 0;
    @(posedge clk);
    #1 check_reset();
    @(posedge clk);
    #1 check_reset();
    run_dump(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) begin
        rf[0][i] = {$urandom, $urandom};
        rf[1][i] = {$urandom, $urandom};
      end
      run_dump(1'(k), 2, k >= 2 ? $urandom_range(1, 25) : 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_dump_unit.md
REGFILE_DUMP_UNIT -- requirements
Module: regfile_dump_unit

Interface
REQ-001 The block SHALL take the parameter XLEN, default 64, as the register data width.
REQ-002 The block SHALL take the parameter NUM_REGS, default 32, as the number of architectural registers scanned.
REQ-003 The block SHALL take the parameter SKIP_X0, default 0; when 1, index 0 is not emitted.
REQ-004 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a dump.
- abort  in  1  cancels a dump in progress.
- rf_raddr  out  5  register file read address.
- rf_rdata  in  XLEN  register file read data, combinational from rf_raddr.
- dump_valid  out  1  dump_index/dump_data/dump_last are valid.
- dump_ready  in  1  consumer accepts the current beat.
- dump_index  out  5  register number of the current beat.
- dump_data  out  XLEN  register value of the current beat.
- dump_last  out  1  current beat is the final register.
- busy  out  1  a dump is in progress.
- done  out  1  one-cycle pulse after a completed dump.
- checksum  out  XLEN  sum modulo 2^XLEN of all emitted dump_data values.

Function
REQ-005 The FSM SHALL have the states IDLE, READ, SEND and DONE.
REQ-006 IDLE SHALL go to READ when start=1, load the index with 0 (1 if SKIP_X0), and clear checksum to 0.
REQ-007 READ SHALL drive rf_raddr = index, register rf_rdata into dump_data and index into dump_index, then go to SEND; READ lasts exactly 1 cycle.
REQ-008 SEND SHALL hold dump_valid=1, and dump_index, dump_data and dump_last SHALL stay stable until a cycle with dump_valid=1 and dump_ready=1 (a handshake).
REQ-009 On a handshake, checksum SHALL add dump_data (wrapping at 2^XLEN).
REQ-010 On a handshake, the FSM SHALL go to DONE if dump_last=1; otherwise it SHALL increment the index and go to READ.
REQ-011 dump_last SHALL be 1 exactly when dump_index = NUM_REGS-1.
REQ-012 DONE SHALL last 1 cycle with done=1, then go to IDLE; checksum SHALL hold its value until the next accepted start.
REQ-013 The latency from start sampled in IDLE to the first dump_valid=1 SHALL be 2 cycles.
REQ-014 With dump_ready held at 1, one beat SHALL complete every 2 cycles.
REQ-015 busy SHALL be 1 in READ, SEND and DONE, and 0 in IDLE.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse, dump_valid=0 from that cycle, and checksum left as the partial sum.
REQ-018 When abort and a handshake occur in the same cycle, abort SHALL win: the beat is counted in checksum but no done pulse is produced.
REQ-019 rf_raddr SHALL equal the current index in all states and 0 in IDLE.
REQ-020 dump_valid SHALL never depend combinationally on dump_ready.

Reset
REQ-021 With reset=0 at a rising edge, the FSM SHALL enter IDLE.
REQ-022 Reset SHALL clear dump_valid, dump_last, busy, done, dump_index, dump_data, checksum and rf_raddr to 0.
REQ-023 Reset asserted mid-dump SHALL abandon the dump with no done pulse, and start SHALL be honoured on the first edge after reset is released.

Structure
REQ-024 The FSM state enum and the constants XLEN_DEFAULT=64 and NUM_REGS_DEFAULT=32 SHALL reside in the shared package riscv_dbg_pkg.
REQ-025 The block SHALL be a single module with no sub-modules; the register file is external and reached only through rf_raddr/rf_rdata.

Verification
REQ-026 Scenario: RF preloaded x[i]=i*3, SKIP_X0=0, dump_ready=1, start pulse -> 32 beats with indices 0..31 and data 0,3,..,93; dump_last only on index 31; done 1 cycle after beat 31; checksum=1488.
REQ-027 Scenario: same preload, dump_ready toggling 1-in-3 -> data/index stable across every stall; same 32 beats; checksum=1488.
REQ-028 Scenario: SKIP_X0=1, x[i]=1 -> first dump_index=1; 31 beats; checksum=31.
REQ-029 Scenario: abort after the 5th handshake -> busy=0 and dump_valid=0 next cycle; no done; checksum equals the sum of the 5 beats.
REQ-030 Scenario: x[31]=2^64-1, all other registers 0, full dump -> checksum=2^64-1; a second dump with x[1]=1 added -> checksum=0 (wrap).
REQ-031 Scenario: reset=0 in SEND, plus a start pulse during SEND -> all outputs 0; the mid-dump start is ignored; after release a new start gives first dump_valid exactly 2 cycles later.
